// File: rtl/dblock_update_ctrl_pkg.sv
// Shared definitions for the DBLOCK update controller and its helpers.
// Latency: n/a (constants, types and a helper function only).
// Backpressure: n/a.
package dblock_update_ctrl_pkg;

  // Default key width; one sweep visits every key value once.
  localparam int KW_DEF = 5;

  // A single write cycle programs one group of this many rules.
  localparam int RULES_PER_GROUP = 8;

  // Controller sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Number of addresses one sweep visits for a given key width.
  function automatic int sweep_len(input int kw);
    return 1 << kw;
  endfunction

endpackage

// File: rtl/dblock_rule_expand.sv
// Expands 8 ternary rules into the per-address write data of a LUTRAM TCAM.
// Latency: combinational.
// Backpressure: none.
// Ports:
//   addr  - key value of the address being written
//   value - rule j value in value[j*KW +: KW]
//   mask  - rule j care bits (1 = compare, 0 = don't care)
//   en    - rule j enable; a disabled rule never matches
//   rules - bit j is 1 when rule j matches addr
module dblock_rule_expand
  import dblock_update_ctrl_pkg::*;
#(
  parameter int KW = KW_DEF
) (
  input  logic [KW-1:0]                 addr,
  input  logic [RULES_PER_GROUP*KW-1:0] value,
  input  logic [RULES_PER_GROUP*KW-1:0] mask,
  input  logic [RULES_PER_GROUP-1:0]    en,
  output logic [RULES_PER_GROUP-1:0]    rules
);

  always_comb begin
    rules = '0;
    for (int j = 0; j < RULES_PER_GROUP; j++) begin
      // Only the cared-about bits have to agree with the rule value.
      rules[j] = en[j] & (((addr ^ value[j*KW +: KW]) & mask[j*KW +: KW]) == '0);
    end
  end

endmodule

// File: rtl/dblock_update_ctrl.sv
// Sequences searches and rule-group updates onto one LUTRAM TCAM data block.
// Latency: search result 1+MATCH_LAT cycles after accept; update busy 2^KW+2 cycles.
// Backpressure: update wins arbitration; s_ready/u_ready low while a sweep runs.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   s_valid/s_ready     - search handshake, s_key is the search key
//   m_valid/m_match     - search result (m_match is the DBLOCK match vector)
//   u_valid/u_ready     - update handshake; u_flush clears every rule,
//                         otherwise u_group/u_value/u_mask/u_en program 8 rules
//   u_done              - one-cycle pulse when an update or flush finishes
//   sk/clr/we/rules     - DBLOCK control and write data
//   dblk_match          - DBLOCK match vector
module dblock_update_ctrl
  import dblock_update_ctrl_pkg::*;
#(
  parameter int KW        = KW_DEF,
  parameter int D         = 64,
  parameter int MATCH_LAT = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [KW-1:0]                 s_key,
  output logic                          m_valid,
  output logic [D-1:0]                  m_match,
  input  logic                          u_valid,
  output logic                          u_ready,
  input  logic                          u_flush,
  input  logic [$clog2(D/8)-1:0]        u_group,
  input  logic [RULES_PER_GROUP*KW-1:0] u_value,
  input  logic [RULES_PER_GROUP*KW-1:0] u_mask,
  input  logic [RULES_PER_GROUP-1:0]    u_en,
  output logic                          u_done,
  output logic [KW-1:0]                 sk,
  output logic                          clr,
  output logic [D/8-1:0]                we,
  output logic [RULES_PER_GROUP-1:0]    rules,
  input  logic [D-1:0]                  dblk_match
);

  localparam int G  = D / RULES_PER_GROUP;
  localparam int GW = $clog2(G);
  localparam logic [KW-1:0] ONE  = KW'(1);
  localparam logic [KW-1:0] LAST = KW'(sweep_len(KW) - 1);

  state_t                          state;
  logic [KW-1:0]                   cnt;
  logic                            flush_q;
  logic [GW-1:0]                   group_q;
  logic [RULES_PER_GROUP*KW-1:0]   value_q;
  logic [RULES_PER_GROUP*KW-1:0]   mask_q;
  logic [RULES_PER_GROUP-1:0]      en_q;
  logic [MATCH_LAT:0]              vld_sr;
  logic                            search_acc;

  logic [KW-1:0]                   x_addr;
  logic [RULES_PER_GROUP*KW-1:0]   x_value;
  logic [RULES_PER_GROUP*KW-1:0]   x_mask;
  logic [RULES_PER_GROUP-1:0]      x_en;
  logic [RULES_PER_GROUP-1:0]      x_rules;
  logic [G-1:0]                    grp_onehot;

  assign u_ready    = (state == IDLE);
  assign s_ready    = (state == IDLE) & ~u_valid & ~rst;
  assign search_acc = s_valid & s_ready;
  assign m_valid    = vld_sr[MATCH_LAT];
  assign m_match    = dblk_match;
  // All clearing goes through flush sweeps so every write is sequenced here.
  assign clr        = 1'b0;

  // The write data is registered, so the expander always works one address
  // ahead: address 0 with the incoming fields at accept, cnt+1 during a sweep.
  always_comb begin
    grp_onehot = G'(1) << u_group;
    if (state == IDLE) begin
      x_addr  = '0;
      x_value = u_value;
      x_mask  = u_mask;
      x_en    = u_en;
    end else begin
      x_addr  = cnt + ONE;
      x_value = value_q;
      x_mask  = mask_q;
      x_en    = en_q;
    end
  end

  dblock_rule_expand #(.KW(KW)) u_expand (
    .addr  (x_addr),
    .value (x_value),
    .mask  (x_mask),
    .en    (x_en),
    .rules (x_rules)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      sk      <= '0;
      we      <= '0;
      rules   <= '0;
      u_done  <= 1'b0;
      vld_sr  <= '0;
      flush_q <= 1'b0;
      group_q <= '0;
      value_q <= '0;
      mask_q  <= '0;
      en_q    <= '0;
    end else begin
      vld_sr <= {vld_sr[MATCH_LAT-1:0], search_acc};
      u_done <= 1'b0;
      case (state)
        IDLE: begin
          we    <= '0;
          rules <= '0;
          if (u_valid) begin
            flush_q <= u_flush;
            group_q <= u_group;
            value_q <= u_value;
            mask_q  <= u_mask;
            en_q    <= u_en;
            cnt     <= '0;
            sk      <= '0;
            we      <= u_flush ? {G{1'b1}} : grp_onehot;
            rules   <= u_flush ? '0 : x_rules;
            state   <= SWEEP;
          end else if (s_valid) begin
            // An in-flight search keeps this sk for one cycle, so its match
            // is sampled before any later sweep starts writing.
            sk <= s_key;
          end
        end
        SWEEP: begin
          if (cnt == LAST) begin
            we     <= '0;
            rules  <= '0;
            u_done <= 1'b1;
            state  <= DONE;
          end else begin
            cnt   <= cnt + ONE;
            sk    <= cnt + ONE;
            rules <= flush_q ? '0 : x_rules;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
